// File: rtl/cache_nwsa_wb.sv
// N-way set-associative, write-back, write-allocate cache with burst line fill and writeback.
// Define CACHE_STATS_EN to add saturating hit/miss/writeback counters.
module cache_nwsa_wb #(
  parameter int AWIDTH     = 16,
  parameter int DWIDTH     = 32,
  parameter int NUMWAYS    = 4,
  parameter int NUMSETS    = 16,
  parameter int BLOCKWORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              stall_cpu,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rvalid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);
  localparam int OFFW = $clog2(BLOCKWORDS);
  localparam int IDXW = $clog2(NUMSETS);
  localparam int TAGW = AWIDTH - IDXW - OFFW;
  localparam int WAYW = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_REFILLDONE} state_t;

  state_t              r_state;
  logic [AWIDTH-1:0]   r_addr;
  logic                r_we;
  logic [DWIDTH-1:0]   r_wdata;
  logic [WAYW-1:0]     r_victim;
  logic [OFFW-1:0]     r_beat;
  logic                r_fill_acc;
  logic                r_replay;

  logic [TAGW-1:0]     r_tag   [NUMSETS][NUMWAYS];
  logic [DWIDTH-1:0]   r_data  [NUMSETS][NUMWAYS][BLOCKWORDS];
  logic [NUMWAYS-1:0]  r_valid [NUMSETS];
  logic [NUMWAYS-1:0]  r_dirty [NUMSETS];
  logic [WAYW-1:0]     r_ptr   [NUMSETS];

  logic [TAGW-1:0]     w_tag;
  logic [IDXW-1:0]     w_idx;
  logic [OFFW-1:0]     w_off;
  logic                w_hit;
  logic [WAYW-1:0]     w_hit_way;
  logic                w_inv;
  logic [WAYW-1:0]     w_inv_way;
  logic [WAYW-1:0]     w_victim;
  logic                w_beat_last;
  logic [OFFW-1:0]     w_beat_nxt;
  logic                w_fill_take;

  assign w_tag       = r_addr[AWIDTH-1 -: TAGW];
  assign w_idx       = r_addr[OFFW +: IDXW];
  assign w_off       = r_addr[OFFW-1:0];
  assign w_beat_last = (r_beat == OFFW'(BLOCKWORDS-1));
  assign w_beat_nxt  = r_beat + OFFW'(1);
  // A fill beat arriving together with the request handshake counts as beat 0.
  assign w_fill_take = mem_rvalid && (r_fill_acc || (mem_req && mem_ready));

  // Descending scan leaves the lowest-numbered match/invalid way selected.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int i = NUMWAYS-1; i >= 0; i--) begin
      if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(i);
      end
      if (!r_valid[w_idx][i]) begin
        w_inv     = 1'b1;
        w_inv_way = WAYW'(i);
      end
    end
    w_victim = w_inv ? w_inv_way : r_ptr[w_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_victim   <= '0;
      r_beat     <= '0;
      r_fill_acc <= 1'b0;
      r_replay   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      stall_cpu  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      for (int s = 0; s < NUMSETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_ptr[s]   <= '0;
      end
`ifdef CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr    <= cpu_addr;
            r_we      <= cpu_we;
            r_wdata   <= cpu_wdata;
            stall_cpu <= 1'b1;
            r_state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (r_we) begin
              r_data[w_idx][w_hit_way][w_off] <= r_wdata;
              r_dirty[w_idx][w_hit_way]       <= 1'b1;
            end else begin
              cpu_rdata <= r_data[w_idx][w_hit_way][w_off];
            end
            cpu_ack   <= 1'b1;
            stall_cpu <= 1'b0;
            r_replay  <= 1'b0;
            r_state   <= S_IDLE;
`ifdef CACHE_STATS_EN
            if (!r_replay && (hit_count != '1)) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            r_victim <= w_victim;
            r_beat   <= '0;
            mem_req  <= 1'b1;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {r_tag[w_idx][w_victim], w_idx, {OFFW{1'b0}}};
              mem_wdata <= r_data[w_idx][w_victim][0];
              r_state   <= S_WRITEBACK;
            end else begin
              mem_we                   <= 1'b0;
              mem_addr                 <= {w_tag, w_idx, {OFFW{1'b0}}};
              r_valid[w_idx][w_victim] <= 1'b0;
              r_fill_acc               <= 1'b0;
              r_state                  <= S_FILL;
            end
`ifdef CACHE_STATS_EN
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            if (w_beat_last) begin
              r_beat                   <= '0;
              r_dirty[w_idx][r_victim] <= 1'b0;
              r_valid[w_idx][r_victim] <= 1'b0;
              mem_req                  <= 1'b0;
              mem_we                   <= 1'b0;
              mem_addr                 <= {w_tag, w_idx, {OFFW{1'b0}}};
              mem_wdata                <= '0;
              r_fill_acc               <= 1'b0;
              r_state                  <= S_FILL;
`ifdef CACHE_STATS_EN
              if (wb_count != '1) wb_count <= wb_count + 32'd1;
`endif
            end else begin
              r_beat    <= w_beat_nxt;
              mem_wdata <= r_data[w_idx][r_victim][w_beat_nxt];
            end
          end
        end
        S_FILL: begin
          if (!r_fill_acc) begin
            if (mem_req && mem_ready) begin
              mem_req    <= 1'b0;
              r_fill_acc <= 1'b1;
            end else begin
              mem_req <= 1'b1;
            end
          end
          if (w_fill_take) begin
            r_data[w_idx][r_victim][r_beat] <= mem_rdata;
            if (w_beat_last) begin
              r_beat     <= '0;
              r_fill_acc <= 1'b0;
              mem_req    <= 1'b0;
              r_state    <= S_REFILLDONE;
            end else begin
              r_beat <= w_beat_nxt;
            end
          end
        end
        S_REFILLDONE: begin
          r_tag[w_idx][r_victim]   <= w_tag;
          r_valid[w_idx][r_victim] <= 1'b1;
          r_dirty[w_idx][r_victim] <= 1'b0;
          if (r_victim == r_ptr[w_idx])
            r_ptr[w_idx] <= (r_ptr[w_idx] == WAYW'(NUMWAYS-1)) ? '0 : r_ptr[w_idx] + WAYW'(1);
          r_replay <= 1'b1;
          r_state  <= S_LOOKUP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_nwsa_wb.sv
// Directed scoreboard bench for cache_nwsa_wb: CPU responses, writeback beats and fill
// addresses are queued as expectations and checked by independent monitors.
`timescale 1ns/1ps
module tb_cache_nwsa_wb;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        stall_cpu;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  always #5 clock = ~clock;

  cache_nwsa_wb dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .stall_cpu(stall_cpu),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  typedef struct packed {logic we; logic [31:0] data;} cpu_exp_t;
  typedef struct packed {logic [15:0] addr; logic [31:0] data;} wb_exp_t;

  cpu_exp_t    exp_cpu[$];
  wb_exp_t     exp_wb[$];
  logic [15:0] exp_fill[$];
  logic [31:0] mem_img [0:65535];

  int tests_run = 0;
  int tests_failed = 0;

  int  wb_beat = 0, wb_hold = 0, fill_beat = 0;
  int  mem_req_cycles = 0, wb_count = 0, fill_count = 0;
  bit  hold_armed = 0, fill_act = 0, same_cycle = 0;
  logic [15:0] fill_base = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: %s", name, why);
  endtask

  // CPU response monitor
  always @(negedge clock) begin : cpu_mon
    cpu_exp_t e;
    if (cpu_ack) begin
      if (exp_cpu.size() == 0) fail_now("unexpected_ack", "cpu_ack=1 with no access outstanding, expected 0");
      else begin
        e = exp_cpu.pop_front();
        if (e.we) chk("write_ack_stall", 32'(stall_cpu), 32'd0);
        else      chk("read_data", cpu_rdata, e.data);
      end
    end
  end

  // Burst memory model and memory-side monitor
  always @(negedge clock) begin : mem_model
    logic        rdy, rv;
    logic [31:0] rd;
    wb_exp_t     w;
    rdy = 1'b0; rv = 1'b0; rd = '0;
    if (reset) begin
      fill_act = 0; fill_beat = 0; wb_beat = 0; wb_hold = 0;
    end else begin
      if (mem_req) mem_req_cycles++;
      if (mem_req && mem_we) begin
        w = (exp_wb.size() > 0) ? exp_wb[0] : '0;
        if (wb_hold > 0) begin
          wb_hold--;
          chk("wb_hold_wdata", mem_wdata, w.data);
          chk("wb_hold_addr", 32'(mem_addr), 32'(w.addr));
          chk("wb_hold_stall", 32'(stall_cpu), 32'd1);
        end else begin
          rdy = 1'b1;
          if (exp_wb.size() == 0) fail_now("wb_unexpected", "writeback beat with none expected");
          else begin
            w = exp_wb.pop_front();
            chk("wb_addr", 32'(mem_addr), 32'(w.addr));
            chk("wb_data", mem_wdata, w.data);
          end
          mem_img[mem_addr + 16'(wb_beat)] = mem_wdata;
          wb_beat++;
          if (wb_beat == 4) begin wb_beat = 0; wb_count++; end
          if (wb_beat == 2 && hold_armed) begin wb_hold = 5; hold_armed = 0; end
        end
      end else if (mem_req && !mem_we && !fill_act) begin
        rdy = 1'b1;
        fill_count++;
        if (exp_fill.size() == 0) fail_now("fill_unexpected", "fill request with none expected");
        else chk("fill_addr", 32'(mem_addr), 32'(exp_fill.pop_front()));
        fill_act = 1; fill_base = mem_addr; fill_beat = 0;
        if (same_cycle) begin rv = 1'b1; rd = mem_img[fill_base]; fill_beat = 1; end
        same_cycle = !same_cycle;
      end else if (fill_act) begin
        rv = 1'b1;
        rd = mem_img[fill_base + 16'(fill_beat)];
        fill_beat++;
        if (fill_beat == 4) fill_act = 0;
      end
    end
    mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
  end

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                            input logic [31:0] exp, output int lat);
    cpu_exp_t e;
    e.we = we; e.data = exp;
    exp_cpu.push_back(e);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!cpu_ack && lat < 300);
    if (!cpu_ack) fail_now("ack_timeout", $sformatf("no cpu_ack for addr 0x%04h within 300 cycles", a));
    cpu_req = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_stall"}, 32'(stall_cpu), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, snap, n;
    logic [15:0] addrs [3];
    wb_exp_t w;
    for (int i = 0; i < 65536; i++) mem_img[i] = 32'h1000_0000 | 32'(i);
    mem_img[16'h0040] = 32'hA0; mem_img[16'h0041] = 32'hA1;
    mem_img[16'h0042] = 32'hA2; mem_img[16'h0043] = 32'hA3;

    repeat (3) @(negedge clock);
    chk_outputs_zero("reset");
    reset = 1'b0;

    exp_fill.push_back(16'h0040);
    cpu_access(1'b0, 16'h0040, 32'h0, 32'hA0, lat);
    chk("first_fill_no_wb", 32'(wb_count), 32'd0);

    snap = mem_req_cycles;
    cpu_access(1'b0, 16'h0041, 32'h0, 32'hA1, lat);
    chk("hit_rd_latency", 32'(lat), 32'd2);
    chk("hit_rd_no_mem", 32'(mem_req_cycles), 32'(snap));

    snap = mem_req_cycles;
    cpu_access(1'b1, 16'h0042, 32'hDEADBEEF, 32'h0, lat);
    chk("hit_wr_latency", 32'(lat), 32'd2);
    chk("hit_wr_no_mem", 32'(mem_req_cycles), 32'(snap));
    cpu_access(1'b0, 16'h0042, 32'h0, 32'hDEADBEEF, lat);
    chk("hit_rd2_latency", 32'(lat), 32'd2);

    addrs[0] = 16'h0080; addrs[1] = 16'h00C0; addrs[2] = 16'h0100;
    for (int k = 0; k < 3; k++) begin
      exp_fill.push_back(addrs[k]);
      cpu_access(1'b0, addrs[k], 32'h0, 32'h1000_0000 | 32'(addrs[k]), lat);
    end
    chk("clean_fills_no_wb", 32'(wb_count), 32'd0);

    // Set 0 is full; round-robin picks dirty way 0 (tag 1)
    w.addr = 16'h0040;
    w.data = 32'hA0;       exp_wb.push_back(w);
    w.data = 32'hA1;       exp_wb.push_back(w);
    w.data = 32'hDEADBEEF; exp_wb.push_back(w);
    w.data = 32'hA3;       exp_wb.push_back(w);
    exp_fill.push_back(16'h0140);
    hold_armed = 1;
    cpu_access(1'b0, 16'h0140, 32'h0, 32'h1000_0140, lat);
    chk("evict_wb_count", 32'(wb_count), 32'd1);
    chk("evict_mem_word", mem_img[16'h0042], 32'hDEADBEEF);

    // Next victim is clean way 1; the refetched line carries the written-back word
    exp_fill.push_back(16'h0040);
    cpu_access(1'b0, 16'h0040, 32'h0, 32'hA0, lat);
    cpu_access(1'b0, 16'h0042, 32'h0, 32'hDEADBEEF, lat);
    chk("refetch_hit_latency", 32'(lat), 32'd2);
    chk("refetch_no_wb", 32'(wb_count), 32'd1);

    // Write miss in set 6 allocates, then merges the store
    exp_fill.push_back(16'h0018);
    cpu_access(1'b1, 16'h0019, 32'h12345678, 32'h0, lat);
    cpu_access(1'b0, 16'h0019, 32'h0, 32'h12345678, lat);
    chk("wmiss_hit_latency", 32'(lat), 32'd2);
    cpu_access(1'b0, 16'h001A, 32'h0, 32'h1000_001A, lat);

    // Reset while the second fill beat is presented
    exp_fill.push_back(16'h0200);
    snap = fill_count;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    n = 0;
    do begin @(negedge clock); #1; n++; end while (!(fill_act && fill_beat == 2) && n < 300);
    if (n >= 300) fail_now("rst_fill_timeout", "second fill beat never presented");
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clock); #1;
    chk_outputs_zero("midburst_reset");
    reset = 1'b0;
    exp_fill.push_back(16'h0200);
    cpu_access(1'b0, 16'h0200, 32'h0, 32'h1000_0200, lat);
    chk("rst_refill_count", 32'(fill_count), 32'(snap + 2));

    repeat (3) @(negedge clock);
    chk("cpu_queue_empty", 32'(exp_cpu.size()), 32'd0);
    chk("wb_queue_empty", 32'(exp_wb.size()), 32'd0);
    chk("fill_queue_empty", 32'(exp_fill.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
